// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Contents:
//   InstAddrBus / InstBus - 32-bit address and instruction buses
//   fq_entry_t            - one queued entry {pc, inst}
//   INST_NOP              - canonical no-op instruction (addi x0, x0, 0)
//   PC_STEP               - sequential fetch increment
//   align_pc()            - forces a fetch address onto a word boundary
package inst_fetch_queue_pkg;

    typedef logic [31:0] InstAddrBus;
    typedef logic [31:0] InstBus;

    typedef struct packed {
        InstAddrBus pc;
        InstBus     inst;
    } fq_entry_t;

    localparam InstBus     INST_NOP = 32'h0000_0013;
    localparam InstAddrBus PC_STEP  = 32'd4;

    // Masking keeps every bit of the input in use while clearing [1:0].
    function automatic InstAddrBus align_pc(input InstAddrBus pc);
        return pc & ~InstAddrBus'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_ring.sv
// Circular buffer of DEPTH fq_entry_t entries with push, pop and clear.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (zeroes all entries)
//   clear_i      - empties the buffer (pointers and occupancy to 0), data kept
//   push_i       - write push_data_i at the tail
//   push_data_i  - entry to write
//   pop_i        - advance the head; caller guarantees occ_o != 0
//   head_o       - entry at the head, read straight from storage
//   occ_o        - number of valid entries, 0..DEPTH
module fq_ring
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  fq_entry_t                  push_data_i,
    input  logic                       pop_i,
    output fq_entry_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [CW-1:0]     occ_q;

    // Pointers are exactly PW bits wide, so DEPTH being a power of two makes
    // the natural binary overflow the modulo-DEPTH wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else if (clear_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_data_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            occ_q <= occ_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o = mem_q[head_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues credit-limited in-order
// requests to a variable-latency instruction memory, buffers returned
// instructions with their PCs and presents them to decode. A redirect empties
// the queue and marks every request still in flight as wrong-path.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   redirect_valid/_pc        - flush and restart fetch at redirect_pc
//   req_valid/ready/addr      - fetch request channel to memory
//   resp_valid/inst           - in-order responses, no backpressure
//   out_valid/ready/inst/pc   - queue head to decode
//   resp_err                  - sticky: response with nothing outstanding
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter InstAddrBus RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  InstAddrBus  redirect_pc,
    output logic        req_valid,
    input  logic        req_ready,
    output InstAddrBus  req_addr,
    input  logic        resp_valid,
    input  InstBus      resp_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output InstBus      out_inst,
    output InstAddrBus  out_pc,
    output logic        resp_err
);

    localparam int CW = $clog2(DEPTH + 1);

    InstAddrBus    fetch_pc_q, fetch_pc_d;
    InstAddrBus    resp_pc_q,  resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q,     drop_d;
    logic          err_q,      err_d;

    logic [CW-1:0] occ;
    logic [CW:0]   credit_used;
    logic          req_fire;
    logic          resp_ok;
    logic          push;
    logic          pop;
    fq_entry_t     head;

    // Credit uses registered occupancy only, so a pop frees its slot one cycle
    // later and out_ready has no combinational path to req_valid.
    assign credit_used = {1'b0, occ} + {1'b0, inflight_q};
    assign req_valid   = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign req_fire    = req_valid && req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok = resp_valid && (inflight_q != '0);
    assign push    = resp_ok && (drop_q == '0) && !redirect_valid;
    assign pop     = out_valid && out_ready && !redirect_valid;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);
        drop_d     = drop_q;
        err_d      = err_q | (resp_valid && (inflight_q == '0));

        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            resp_pc_d  = align_pc(redirect_pc);
            // Every request still outstanding after this cycle is wrong-path;
            // drop never exceeds inflight, so this total already covers it.
            drop_d     = inflight_q - CW'(resp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            if (resp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    fq_ring #(
        .DEPTH(DEPTH)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ('{pc: resp_pc_q, inst: resp_inst}),
        .pop_i       (pop),
        .head_o      (head),
        .occ_o       (occ)
    );

    assign req_addr  = fetch_pc_q;
    assign out_valid = (occ != '0);
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue. A memory model returns responses
// in order with random latency; the reference model tags each request with the
// redirect epoch it was issued in and keeps only responses whose epoch is
// still current, holding the expected decode stream in a queue.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int         DEPTH    = 4;
    localparam InstAddrBus RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        resp_err;

    inst_fetch_queue #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_inst     (resp_inst),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .resp_err      (resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    req_t        outq[$];
    ent_t        mq[$];
    logic [31:0] exp_fetch;
    bit          exp_err;
    int          epoch;
    int          cyc;
    int          n_cmp;
    int          n_mis;
    int          n_pops;
    int          n_drop_seen;

    function automatic logic [31:0] mem_inst(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ INST_NOP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
        chk("rst_req_addr",  req_addr, RESET_PC);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_inst",  out_inst, 32'd0);
        chk("rst_out_pc",    out_pc, 32'd0);
        chk("rst_resp_err",  {31'b0, resp_err}, 32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        outq.delete();
        exp_fetch = RESET_PC;
        exp_err   = 1'b0;
        epoch++;
    endtask

    // One clock: drive at negedge, check after settling, update model at posedge.
    task automatic run_cycle(input int p_rdy, input int p_out, input int p_redir,
                             input int lat_lo, input int lat_hi, input bit force_resp);
        bit   exp_rv, fire, pop;
        req_t r;
        int   d;
        @(negedge clk);
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = $urandom;
        req_ready      = ($urandom_range(99) < p_rdy);
        out_ready      = ($urandom_range(99) < p_out);
        if (force_resp) begin
            resp_valid = 1'b1;
            resp_inst  = $urandom;
        end else begin
            resp_valid = (outq.size() > 0) && (outq[0].due <= cyc);
            resp_inst  = resp_valid ? mem_inst(outq[0].addr) : $urandom;
        end
        #1;
        exp_rv = !redirect_valid && ((mq.size() + outq.size()) < DEPTH);
        chk("req_valid", {31'b0, req_valid}, {31'b0, exp_rv});
        chk("req_addr",  req_addr, exp_fetch);
        chk("out_valid", {31'b0, out_valid}, {31'b0, (mq.size() > 0)});
        if (mq.size() > 0) begin
            chk("out_pc",   out_pc,   mq[0].pc);
            chk("out_inst", out_inst, mq[0].inst);
        end
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        fire = exp_rv && req_ready;
        pop  = !redirect_valid && (mq.size() > 0) && out_ready;
        @(posedge clk);
        if (pop) begin
            void'(mq.pop_front());
            n_pops++;
        end
        if (resp_valid) begin
            if (outq.size() == 0) begin
                exp_err = 1'b1;
            end else begin
                r = outq.pop_front();
                if (!redirect_valid && (r.epoch == epoch)) begin
                    mq.push_back('{pc: r.addr, inst: mem_inst(r.addr)});
                end else begin
                    n_drop_seen++;
                end
            end
        end
        if (redirect_valid) begin
            mq.delete();
            epoch++;
            exp_fetch = redirect_pc & ~32'd3;
        end else if (fire) begin
            d = cyc + $urandom_range(lat_hi, lat_lo);
            if ((outq.size() > 0) && (d <= outq[outq.size()-1].due)) begin
                d = outq[outq.size()-1].due + 1;
            end
            outq.push_back('{addr: exp_fetch, epoch: epoch, due: d});
            exp_fetch = exp_fetch + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        int guard;
        n_cmp = 0; n_mis = 0; n_pops = 0; n_drop_seen = 0;
        cyc = 0; epoch = 0;
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_inst = '0; out_ready = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);

        // Streaming at latency 1, everything ready.
        repeat (40) run_cycle(100, 100, 0, 1, 1, 1'b0);
        // Decode stalled at latency 2: queue fills and credit closes.
        repeat (30) run_cycle(100, 0, 0, 2, 2, 1'b0);
        chk("full_occ", mq.size(), DEPTH);
        repeat (10) run_cycle(100, 100, 0, 2, 2, 1'b0);
        // Mixed traffic with occasional redirects.
        repeat (300) run_cycle(70, 60, 8, 1, 4, 1'b0);
        // Heavy redirect traffic at latency 3, including back-to-back redirects.
        repeat (200) run_cycle(90, 70, 30, 3, 3, 1'b0);
        repeat (100) run_cycle(100, 80, 15, 1, 5, 1'b0);

        // Drain the memory, then inject a response with nothing outstanding.
        guard = 0;
        while ((outq.size() > 0) && (guard < 60)) begin
            run_cycle(0, 0, 0, 1, 1, 1'b0);
            guard++;
        end
        chk("drain_done", outq.size(), 32'd0);
        run_cycle(0, 0, 0, 1, 1, 1'b1);
        repeat (6) run_cycle(0, 0, 0, 1, 1, 1'b0);
        chk("err_sticky", {31'b0, resp_err}, 32'd1);
        repeat (20) run_cycle(100, 100, 0, 1, 3, 1'b0);

        // Reset returns to the reset state; memory is reset together with it.
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        repeat (20) run_cycle(100, 100, 0, 1, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
